jtag_scan_sequencer: RTL and testbench
======================================

JTAG_SCAN_SEQUENCER -- requirements
Module: jtag_scan_sequencer

Interface
REQ-001 Parameter BSC_Reg_size, default 14: maximum scan length in bits, and the width of the pattern and capture registers.
REQ-002 Parameter IR_size, default 3: instruction-register length; scan_len is ignored for IR scans.
REQ-003 TCK  input  1  single clock; all state changes on posedge TCK.
REQ-004 TRSTZ  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  request a scan; sampled only in S_IDLE.
REQ-006 is_ir  input  1  1 = instruction scan, 0 = data scan; sampled with start.
REQ-007 scan_len  input  $clog2(BSC_Reg_size+1)  data-scan bit count; sampled with start.
REQ-008 scan_pattern  input  BSC_Reg_size  bits to shift out, LSB first; sampled with start.
REQ-009 TDO  input  1  serial return from the device under test.
REQ-010 TMS  output  1  registered TAP mode select.
REQ-011 to_TDI  output  1  registered serial data to the device.
REQ-012 busy  output  1  high from the cycle after an accepted start until done.
REQ-013 done  output  1  one-cycle pulse when the scan completes.
REQ-014 captured  output  BSC_Reg_size  TDO bits of the last scan, LSB = first bit; valid from done until the next accepted start.

Function
REQ-015 The FSM SHALL have states S_IDLE, S_SEL_DR, S_SEL_IR, S_CAPTURE, S_SHIFT, S_EXIT1, S_UPDATE.
REQ-016 TMS per state SHALL be: S_IDLE 0; S_SEL_DR 1 for IR scans, 0 for DR scans; S_SEL_IR 0; S_CAPTURE 0; S_SHIFT 0; S_EXIT1 1; S_UPDATE 1.
REQ-017 A DR scan SHALL emit the TMS sequence 1,0,0,(0 x len-1),1,1,0 starting the cycle after start.
REQ-018 An IR scan SHALL emit the TMS sequence 1,1,0,0,(0 x IR_size-1),1,1,0, with len = IR_size.
REQ-019 Transitions SHALL be: S_IDLE to S_SEL_DR on start with len != 0; S_SEL_DR to S_SEL_IR if is_ir, else to S_CAPTURE; S_SEL_IR to S_CAPTURE; S_CAPTURE to S_SHIFT, or to S_EXIT1 if len = 1; S_SHIFT to S_EXIT1 when the bit counter reaches len-1; S_EXIT1 to S_UPDATE; S_UPDATE to S_IDLE with done = 1.
REQ-020 to_TDI SHALL present pattern bit k while the FSM is in the state of shifted bit k (S_SHIFT, or S_EXIT1 for the last bit), and SHALL be 0 otherwise.
REQ-021 TDO SHALL be sampled into bit k of the capture register on the posedge that leaves the state presenting bit k.
REQ-022 start with len = 0 (DR scan) SHALL be ignored: no busy, no done.
REQ-023 scan_len > BSC_Reg_size SHALL be clamped to BSC_Reg_size.
REQ-024 start while busy SHALL be ignored; no queuing.
REQ-025 Captured bits at or above len SHALL read 0.
REQ-026 Total latency from the start edge to done SHALL be len+5 cycles for DR scans and IR_size+6 cycles for IR scans.

Reset
REQ-027 With TRSTZ = 0 at a posedge: state = S_IDLE, TMS = 1, to_TDI = 0, busy = 0, done = 0, captured = 0, and counters cleared.
REQ-028 Reset mid-scan SHALL abort the scan without asserting done.
REQ-029 After reset, TMS SHALL be held at 1 for 5 cycles (S_IDLE with a reset counter) before the first start is accepted and before TMS drops to 0, forcing the device TAP to Test-Logic-Reset and then Run-Test/Idle.

Configuration
REQ-030 Macro SCAN_CAPTURE_EN SHALL select the capture feature.
REQ-031 Defined: TDO is sampled per REQ-021 and driven on captured.
REQ-032 Undefined: no capture register is built, captured is tied to 0, TDO is unused, and all timing is unchanged.

Structure
REQ-033 Package jtag_seq_pkg SHALL hold the state enum, the TMS constants, and the post-reset hold count of 5.
REQ-034 Sub-module scan_shift_reg SHALL implement the load/shift-right pattern register, with inputs load, shift, TCK and TRSTZ and output bit 0.
REQ-035 The FSM and counters SHALL reside in jtag_scan_sequencer.

Verification
REQ-036 Reset, then idle: TMS = 1 for 5 cycles then 0; start during the hold is ignored; busy = 0.
REQ-037 DR scan, len = 14, pattern 14'h2A5B, TDO looped to to_TDI through one flop:
- TMS = 1,0,0,0x13,1,1,0.
- done at cycle 19; captured = 14'h2A5B.
REQ-038 IR scan, pattern 3'b101, TDO = 1 constant:
- TMS = 1,1,0,0,0,0,1,1,0.
- to_TDI = 1,0,1; captured = 14'h0007.
REQ-039 DR scan, len = 1, pattern 1: S_CAPTURE goes directly to S_EXIT1; to_TDI = 1 for one cycle; done at cycle 6.
REQ-040 Boundary cases:
- len = 0: no response.
- len = 20: clamped to 14.
- start asserted while busy: ignored.
REQ-041 TRSTZ low during S_SHIFT bit 5: no done, outputs at reset values, next scan correct; repeat with SCAN_CAPTURE_EN undefined and expect captured = 0.

Source files
------------

// File: rtl/jtag_seq_pkg.sv
// Shared definitions for the JTAG scan sequencer: FSM states, the TMS level
// driven while each state is presented, and the post-reset TAP hold length.
package jtag_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL_DR,
        S_SEL_IR,
        S_CAPTURE,
        S_SHIFT,
        S_EXIT1,
        S_UPDATE
    } seq_state_t;

    localparam logic TMS_RESET     = 1'b1;
    localparam logic TMS_IDLE      = 1'b0;
    localparam logic TMS_RTI_EXIT  = 1'b1;  // walks the TAP out of Run-Test/Idle
    localparam logic TMS_SEL_DR_IR = 1'b1;
    localparam logic TMS_SEL_DR_DR = 1'b0;
    localparam logic TMS_SEL_IR    = 1'b0;
    localparam logic TMS_CAPTURE   = 1'b0;
    localparam logic TMS_SHIFT     = 1'b0;
    localparam logic TMS_EXIT1     = 1'b1;
    localparam logic TMS_UPDATE    = 1'b1;

    localparam int unsigned RESET_HOLD = 5;

    function automatic logic sel_dr_tms(input logic ir);
        return ir ? TMS_SEL_DR_IR : TMS_SEL_DR_DR;
    endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Pattern register for the scan sequencer: parallel load, then shift right
// one bit per shifted TDI bit, exposing the next bit to send on q0.
module scan_shift_reg #(
    parameter int W = 14
) (
    input  logic         TCK,
    input  logic         TRSTZ,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         q0
);

    logic [W-1:0] sr;

    always_ff @(posedge TCK) begin
        if (!TRSTZ)     sr <= '0;
        else if (load)  sr <= d;
        else if (shift) sr <= {1'b0, sr[W-1:1]};
    end

    assign q0 = sr[0];

endmodule

// File: rtl/jtag_scan_sequencer.sv
// JTAG IR/DR scan sequencer: drives TMS/TDI through one full TAP scan per start.
// Define SCAN_CAPTURE_EN to build the TDO capture register; otherwise captured is 0.
module jtag_scan_sequencer
    import jtag_seq_pkg::*;
#(
    parameter int BSC_Reg_size = 14,
    parameter int IR_size      = 3
) (
    input  logic                                  TCK,
    input  logic                                  TRSTZ,
    input  logic                                  start,
    input  logic                                  is_ir,
    input  logic [$clog2(BSC_Reg_size+1)-1:0]     scan_len,
    input  logic [BSC_Reg_size-1:0]               scan_pattern,
    input  logic                                  TDO,
    output logic                                  TMS,
    output logic                                  to_TDI,
    output logic                                  busy,
    output logic                                  done,
    output logic [BSC_Reg_size-1:0]               captured
);

    localparam int LW = $clog2(BSC_Reg_size+1);
    localparam logic [LW-1:0] MAX_LEN = LW'(BSC_Reg_size);
    localparam logic [LW-1:0] IR_LEN  = LW'(IR_size);

    seq_state_t    state;
    logic [LW-1:0] len;
    logic [LW-1:0] bit_cnt;
    logic [2:0]    rst_cnt;
    logic          ir_q;
    logic          hold_done;
    logic          accept;
    logic          shift_en;
    logic          sr_bit;

    assign hold_done = (rst_cnt == 3'(RESET_HOLD));
    assign accept    = (state == S_IDLE) && !busy && hold_done && start &&
                       (is_ir || (scan_len != '0));
    // Leaving CAPTURE or SHIFT always enters a state that presents a fresh bit.
    assign shift_en  = (state == S_CAPTURE) || (state == S_SHIFT);

    scan_shift_reg #(.W(BSC_Reg_size)) u_pattern (
        .TCK   (TCK),
        .TRSTZ (TRSTZ),
        .load  (accept),
        .shift (shift_en),
        .d     (scan_pattern),
        .q0    (sr_bit)
    );

    // Outputs are registered with the state they belong to, so TMS/TDI change
    // on the same edge the state does.
    always_ff @(posedge TCK) begin
        if (!TRSTZ) begin
            state   <= S_IDLE;
            TMS     <= TMS_RESET;
            to_TDI  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            len     <= '0;
            bit_cnt <= '0;
            rst_cnt <= '0;
            ir_q    <= 1'b0;
        end else begin
            done   <= 1'b0;
            to_TDI <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!hold_done) begin
                        rst_cnt <= rst_cnt + 3'd1;
                        TMS     <= TMS_RESET;
                    end else if (busy) begin
                        state <= S_SEL_DR;
                        TMS   <= sel_dr_tms(ir_q);
                    end else if (accept) begin
                        busy <= 1'b1;
                        ir_q <= is_ir;
                        len  <= is_ir ? IR_LEN
                                      : ((scan_len > MAX_LEN) ? MAX_LEN : scan_len);
                        TMS  <= TMS_RTI_EXIT;
                    end else begin
                        TMS <= TMS_IDLE;
                    end
                end
                S_SEL_DR: begin
                    if (ir_q) begin
                        state <= S_SEL_IR;
                        TMS   <= TMS_SEL_IR;
                    end else begin
                        state <= S_CAPTURE;
                        TMS   <= TMS_CAPTURE;
                    end
                end
                S_SEL_IR: begin
                    state <= S_CAPTURE;
                    TMS   <= TMS_CAPTURE;
                end
                S_CAPTURE: begin
                    bit_cnt <= '0;
                    to_TDI  <= sr_bit;
                    if (len == LW'(1)) begin
                        state <= S_EXIT1;
                        TMS   <= TMS_EXIT1;
                    end else begin
                        state <= S_SHIFT;
                        TMS   <= TMS_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bit_cnt <= bit_cnt + LW'(1);
                    to_TDI  <= sr_bit;
                    if (bit_cnt + LW'(1) == len - LW'(1)) begin
                        state <= S_EXIT1;
                        TMS   <= TMS_EXIT1;
                    end else begin
                        TMS <= TMS_SHIFT;
                    end
                end
                S_EXIT1: begin
                    state <= S_UPDATE;
                    TMS   <= TMS_UPDATE;
                end
                S_UPDATE: begin
                    state <= S_IDLE;
                    TMS   <= TMS_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    TMS   <= TMS_IDLE;
                end
            endcase
        end
    end

`ifdef SCAN_CAPTURE_EN
    logic [BSC_Reg_size-1:0] cap;

    // Cleared on accept so bits beyond the scan length read back as 0.
    always_ff @(posedge TCK) begin
        if (!TRSTZ)
            cap <= '0;
        else if (accept)
            cap <= '0;
        else if ((state == S_SHIFT) || (state == S_EXIT1))
            cap[bit_cnt] <= TDO;
    end

    assign captured = cap;
`else
    logic unused_tdo;
    assign unused_tdo = TDO;
    assign captured   = '0;
`endif

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Directed bench for jtag_scan_sequencer: reset hold, DR/IR scans, boundaries.
module tb_jtag_scan_sequencer;

    localparam int W  = 14;
    localparam int LW = 4;

`ifdef SCAN_CAPTURE_EN
    localparam bit CAP_ON = 1'b1;
`else
    localparam bit CAP_ON = 1'b0;
`endif

    logic          TCK = 1'b0;
    logic          TRSTZ = 1'b0;
    logic          start = 1'b0;
    logic          is_ir = 1'b0;
    logic [LW-1:0] scan_len = '0;
    logic [W-1:0]  scan_pattern = '0;
    logic          TDO;
    logic          TMS, to_TDI, busy, done;
    logic [W-1:0]  captured;
    logic          tdo_loop = 1'b1;
    logic          tdo_const = 1'b0;

    int checks = 0;
    int errors = 0;

    jtag_scan_sequencer #(.BSC_Reg_size(W), .IR_size(3)) dut (
        .TCK          (TCK),
        .TRSTZ        (TRSTZ),
        .start        (start),
        .is_ir        (is_ir),
        .scan_len     (scan_len),
        .scan_pattern (scan_pattern),
        .TDO          (TDO),
        .TMS          (TMS),
        .to_TDI       (to_TDI),
        .busy         (busy),
        .done         (done),
        .captured     (captured)
    );

    always #5 TCK = ~TCK;

    // Device model: TDO updates on the falling edge, either echoing TDI or constant.
    always @(negedge TCK) TDO = tdo_loop ? to_TDI : tdo_const;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge TCK);
        #1;
    endtask

    function automatic logic [W-1:0] cap_exp(input logic [W-1:0] v);
        return CAP_ON ? v : '0;
    endfunction

    // Sample n is taken 1 time unit after the n-th edge counted from the start edge (n=1).
    task automatic run_scan(input string tag, input logic ir, input logic [LW-1:0] len,
                            input logic [W-1:0] pat, input int hold, input int exp_done,
                            input logic [31:0] exp_tms, input logic [31:0] exp_tdi,
                            input logic [W-1:0] exp_cap);
        logic [31:0] tms_v, tdi_v, mask;
        int done_at, done_n, nmax;
        tms_v = '0; tdi_v = '0; done_at = 0; done_n = 0;
        nmax = exp_done + 3;
        is_ir = ir; scan_len = len; scan_pattern = pat; start = 1'b1;
        for (int n = 1; n <= nmax; n++) begin
            tick();
            if (n == 1) begin
                chk({tag, "_busy"}, 32'(busy), 32'd1);
                scan_pattern = ~pat;
            end
            if (n >= hold) start = 1'b0;
            tms_v[n-1] = TMS;
            tdi_v[n-1] = to_TDI;
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = n;
            end
        end
        mask = (32'h1 << nmax) - 32'h1;
        chk({tag, "_tms"},    tms_v & mask, exp_tms);
        chk({tag, "_tdi"},    tdi_v & mask, exp_tdi);
        chk({tag, "_doneat"}, 32'(done_at), 32'(exp_done));
        chk({tag, "_donen"},  32'(done_n), 32'd1);
        chk({tag, "_idle"},   32'(busy), 32'd0);
        chk({tag, "_cap"},    32'(captured), 32'(exp_cap));
    endtask

    initial begin
        int busy_n, done_n;

        // Reset values
        repeat (3) tick();
        chk("rst_tms",  32'(TMS), 32'd1);
        chk("rst_tdi",  32'(to_TDI), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cap",  32'(captured), 32'd0);

        // Post-reset hold: TMS high for 5 edges, start ignored meanwhile
        TRSTZ = 1'b1; start = 1'b1; is_ir = 1'b0; scan_len = 4'd4;
        for (int n = 1; n <= 6; n++) begin
            tick();
            if (n == 5) start = 1'b0;
            chk("hold_tms",  32'(TMS), (n <= 5) ? 32'd1 : 32'd0);
            chk("hold_busy", 32'(busy), 32'd0);
        end

        // DR scan, 14 bits, loopback
        tdo_loop = 1'b1;
        run_scan("dr14", 1'b0, 4'd14, 14'h2A5B, 1, 19, 32'h30001, 32'h152D8, cap_exp(14'h2A5B));

        // IR scan, scan_len ignored, TDO stuck at 1
        tdo_loop = 1'b0; tdo_const = 1'b1;
        run_scan("ir", 1'b1, 4'd0, 14'h0005, 1, 9, 32'hC3, 32'h50, cap_exp(14'h0007));

        // Single-bit DR scan
        tdo_loop = 1'b1;
        run_scan("dr1", 1'b0, 4'd1, 14'h0001, 1, 6, 32'h19, 32'h8, cap_exp(14'h0001));

        // Zero-length DR request produces nothing
        is_ir = 1'b0; scan_len = 4'd0; scan_pattern = 14'h1234; start = 1'b1;
        busy_n = 0; done_n = 0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            start = 1'b0;
            busy_n += int'(busy);
            done_n += int'(done);
        end
        chk("len0_busy", 32'(busy_n), 32'd0);
        chk("len0_done", 32'(done_n), 32'd0);
        chk("len0_tms",  32'(TMS), 32'd0);

        // Over-length request clamps to 14 bits
        run_scan("clamp", 1'b0, 4'd15, 14'h3FFF, 1, 19, 32'h30001, 32'h1FFF8, cap_exp(14'h3FFF));

        // start held high while busy must not restart or requeue
        run_scan("busy", 1'b0, 4'd4, 14'h0009, 6, 9, 32'hC1, 32'h48, cap_exp(14'h0009));

        // Reset in the middle of shifting bit 5
        is_ir = 1'b0; scan_len = 4'd14; scan_pattern = 14'h2A5B; start = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            tick();
            start = 1'b0;
        end
        chk("mid_bit5", 32'(to_TDI), 32'd0);
        chk("mid_busy", 32'(busy), 32'd1);
        TRSTZ = 1'b0;
        tick();
        chk("mid_rst_tms",  32'(TMS), 32'd1);
        chk("mid_rst_tdi",  32'(to_TDI), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_cap",  32'(captured), 32'd0);
        TRSTZ = 1'b1;
        done_n = 0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            done_n += int'(done);
        end
        chk("mid_nodone", 32'(done_n), 32'd0);
        run_scan("after", 1'b0, 4'd14, 14'h2A5B, 1, 19, 32'h30001, 32'h152D8, cap_exp(14'h2A5B));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
